// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: handshaked data-RAM access with byte strobes, load extension and timeout.
// Optional macro MEM_ALIGN_CHECK_EN enables misalignment detection and addr_err.
module mem_stage_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                mem_op,
    input  logic [31:0]               result_in,
    input  logic [31:0]               store_data,
    input  logic                      write_reg_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg_addr_in,
    output logic                      ram_en,
    output logic [3:0]                ram_wen,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [31:0]               ram_wdata,
    input  logic [31:0]               ram_rdata,
    input  logic                      ram_ready,
    output logic                      out_valid,
    output logic [31:0]               result_out,
    output logic                      write_reg_en_out,
    output logic [REG_ADDR_WIDTH-1:0] write_reg_addr_out,
    output logic                      addr_err,
    output logic                      bus_err
);

    typedef enum logic [3:0] {
        OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
        OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8
    } mem_op_e;

    typedef enum logic {IDLE, REQ} state_e;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_e state, state_next;

    logic [3:0]                op_q;
    logic [1:0]                off_q;
    logic [31:0]               res_q;
    logic                      wreg_en_q;
    logic [REG_ADDR_WIDTH-1:0] wreg_addr_q;
    logic [CNT_W-1:0]          count;

    logic        accept, is_load, is_store, is_half, is_word, misaligned, timeout_hit;
    logic [1:0]  eff_off;
    logic [3:0]  store_wen;
    logic [31:0] store_wdata, load_data;

    assign in_ready = (state == IDLE);
    assign ram_en   = (state == REQ);
    assign accept   = in_valid && in_ready;

    always_comb begin
        is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
        is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
        is_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
        is_word  = (mem_op == OP_LW) || (mem_op == OP_SW);
        // Offset is truncated to the access size, so an unchecked misaligned access still hits a legal lane.
        if (is_word)      eff_off = 2'b00;
        else if (is_half) eff_off = {result_in[1], 1'b0};
        else              eff_off = result_in[1:0];
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (is_half && result_in[0]) || (is_word && (result_in[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        store_wen   = 4'b0000;
        store_wdata = store_data;
        case (mem_op)
            OP_SB: begin
                store_wen   = 4'b0001 << eff_off;
                store_wdata = {4{store_data[7:0]}};
            end
            OP_SH: begin
                store_wen   = 4'b0011 << eff_off;
                store_wdata = {2{store_data[15:0]}};
            end
            OP_SW: store_wen = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = 8'h00;
        case (off_q)
            2'd0: lane_b = ram_rdata[7:0];
            2'd1: lane_b = ram_rdata[15:8];
            2'd2: lane_b = ram_rdata[23:16];
            2'd3: lane_b = ram_rdata[31:24];
            default: ;
        endcase
        lane_h = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (op_q)
            OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_data = {24'h000000, lane_b};
            OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_data = {16'h0000, lane_h};
            default: load_data = ram_rdata;
        endcase
    end

    // A ram_ready on the final allowed cycle takes priority over the abort.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count == TO_LAST) && !ram_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && (is_load || is_store) && !misaligned) state_next = REQ;
            REQ:  if (ram_ready || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q               <= '0;
            off_q              <= '0;
            res_q              <= '0;
            wreg_en_q          <= 1'b0;
            wreg_addr_q        <= '0;
            count              <= '0;
            ram_wen            <= '0;
            ram_addr           <= '0;
            ram_wdata          <= '0;
            out_valid          <= 1'b0;
            result_out         <= '0;
            write_reg_en_out   <= 1'b0;
            write_reg_addr_out <= '0;
            addr_err           <= 1'b0;
            bus_err            <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            addr_err  <= 1'b0;
            bus_err   <= 1'b0;
            if (accept) begin
                if ((is_load || is_store) && !misaligned) begin
                    op_q        <= mem_op;
                    off_q       <= eff_off;
                    res_q       <= result_in;
                    wreg_en_q   <= write_reg_en_in;
                    wreg_addr_q <= write_reg_addr_in;
                    count       <= '0;
                    ram_wen     <= store_wen;
                    ram_addr    <= {result_in[ADDR_WIDTH-1:2], 2'b00};
                    ram_wdata   <= store_wdata;
                end else begin
                    out_valid          <= 1'b1;
                    addr_err           <= misaligned;
                    result_out         <= result_in;
                    write_reg_en_out   <= write_reg_en_in && !misaligned;
                    write_reg_addr_out <= write_reg_addr_in;
                end
            end else if (state == REQ) begin
                if (ram_ready) begin
                    out_valid          <= 1'b1;
                    result_out         <= (op_q <= OP_LW) ? load_data : res_q;
                    write_reg_en_out   <= (op_q <= OP_LW) && wreg_en_q;
                    write_reg_addr_out <= wreg_addr_q;
                end else if (timeout_hit) begin
                    out_valid          <= 1'b1;
                    bus_err            <= 1'b1;
                    result_out         <= res_q;
                    write_reg_en_out   <= 1'b0;
                    write_reg_addr_out <= wreg_addr_q;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule
